// File: rtl/mc_sequencer.sv
// mc_sequencer
//   Multi-cycle phase sequencer. Walks each instruction through IF/ID/EX/MEM/WB,
//   gating the decoder's static control word into per-cycle strobes. It halts
//   on an unsupported opcode/funct and counts retired instructions.
//
//   State encoding:
//     state | meaning
//     IF  0 | wait for instruction memory, load IR
//     ID  1 | legality check, latch instruction class
//     EX  2 | execute; branches/jumps commit PC here
//     MEM 3 | data memory access, held until dmem_ready
//     WB  4 | register-file write and PC commit
//     HALT 7| illegal instruction seen, frozen until rst
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   op, funct                 instruction fields for the legality check
//   reg_write_d, mem_write_d,
//   memtoreg_d                decoder control word (sampled in ID)
//   imem_ready, dmem_ready    memory handshakes
//   ir_we, pc_we, rf_we,
//   dm_we, instr_done         per-cycle strobes (forced low while rst=1)
//   state                     current phase
//   halted                    sticky illegal-instruction flag
//   retired                   retired-instruction count, wraps
module mc_sequencer #(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             reg_write_d,
    input  logic             mem_write_d,
    input  logic [1:0]       memtoreg_d,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             dm_we,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             halted,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic             cls_rw_q, cls_rw_d;
    logic             cls_mw_q, cls_mw_d;
    logic             cls_ld_q, cls_ld_d;
    logic             halted_q, halted_d;
    logic [RET_W-1:0] retired_q, retired_d;

    logic legal;
    logic ir_we_raw, pc_we_raw, rf_we_raw, dm_we_raw, done_raw;

    always_comb begin
        legal = 1'b0;
        if (op == 6'h00) begin
            case (funct)
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h08: legal = 1'b1;
                default:                                          legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F,
                6'h2B, 6'h23, 6'h04, 6'h02, 6'h03: legal = 1'b1;
                default:                           legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_rw_d  = cls_rw_q;
        cls_mw_d  = cls_mw_q;
        cls_ld_d  = cls_ld_q;
        halted_d  = halted_q;
        ir_we_raw = 1'b0;
        pc_we_raw = 1'b0;
        rf_we_raw = 1'b0;
        dm_we_raw = 1'b0;
        done_raw  = 1'b0;
        case (state_q)
            S_IF: begin
                ir_we_raw = imem_ready;
                if (imem_ready) state_d = S_ID;
            end
            S_ID: begin
                cls_rw_d = reg_write_d;
                cls_mw_d = mem_write_d;
                cls_ld_d = (memtoreg_d == 2'b10);
                if (!legal) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (cls_mw_q || cls_ld_q) begin
                    state_d = S_MEM;
                end else if (cls_rw_q) begin
                    state_d = S_WB;
                end else begin
                    pc_we_raw = 1'b1;
                    done_raw  = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_MEM: begin
                dm_we_raw = cls_mw_q;
                if (dmem_ready) begin
                    if (cls_ld_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_we_raw = 1'b1;
                        done_raw  = 1'b1;
                        state_d   = S_IF;
                    end
                end
            end
            S_WB: begin
                rf_we_raw = 1'b1;
                pc_we_raw = 1'b1;
                done_raw  = 1'b1;
                state_d   = S_IF;
            end
            S_HALT: begin
                halted_d = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    // Strobes are held low for the whole reset pulse, even though state
    // already reads IF and imem_ready may be high.
    assign ir_we      = ir_we_raw & ~rst;
    assign pc_we      = pc_we_raw & ~rst;
    assign rf_we      = rf_we_raw & ~rst;
    assign dm_we      = dm_we_raw & ~rst;
    assign instr_done = done_raw  & ~rst;

    assign retired_d = retired_q + {{(RET_W-1){1'b0}}, instr_done};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            cls_rw_q  <= 1'b0;
            cls_mw_q  <= 1'b0;
            cls_ld_q  <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_rw_q  <= cls_rw_d;
            cls_mw_q  <= cls_mw_d;
            cls_ld_q  <= cls_ld_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer
//   Directed bench for mc_sequencer (RET_W=4 so the retired counter wrap is
//   reachable). Strobe vectors are packed {ir_we,pc_we,rf_we,dm_we,instr_done}.
module tb_mc_sequencer;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op, funct;
    logic          reg_write_d, mem_write_d;
    logic [1:0]    memtoreg_d;
    logic          imem_ready, dmem_ready;
    logic          ir_we, pc_we, rf_we, dm_we, instr_done, halted;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    int checks   = 0;
    int failures = 0;
    logic [RW-1:0] exp_ret = '0;

    localparam logic [4:0] S_NONE  = 5'b00000;
    localparam logic [4:0] S_IR    = 5'b10000;
    localparam logic [4:0] S_WBK   = 5'b01101;
    localparam logic [4:0] S_JMP   = 5'b01001;
    localparam logic [4:0] S_STDN  = 5'b01011;

    mc_sequencer #(.RET_W(RW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
        .memtoreg_d(memtoreg_d), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we),
        .rf_we(rf_we), .dm_we(dm_we), .state(state),
        .instr_done(instr_done), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle's state and strobes, then advance to just after the next edge.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [4:0] estb);
        #1;
        chk({tag, ".state"}, {29'd0, state}, {29'd0, es});
        chk({tag, ".strb"}, {27'd0, ir_we, pc_we, rf_we, dm_we, instr_done}, {27'd0, estb});
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic rw, input logic mw, input logic [1:0] mt);
        op = o; funct = f; reg_write_d = rw; mem_write_d = mw; memtoreg_d = mt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = '0;
    endtask

    initial begin
        rst = 1'b1;
        set_instr(6'h00, 6'h21, 1'b1, 1'b0, 2'b00);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("rst.strb", {27'd0, ir_we, pc_we, rf_we, dm_we, instr_done}, 32'd0);
        chk("rst.state", {29'd0, state}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.retired", {28'd0, retired}, 32'd0);

        // addu
        cyc("addu.if", 3'd0, S_IR);
        cyc("addu.id", 3'd1, S_NONE);
        cyc("addu.ex", 3'd2, S_NONE);
        cyc("addu.wb", 3'd4, S_WBK);
        exp_ret = exp_ret + 1'b1;
        chk("addu.retired", {28'd0, retired}, {28'd0, exp_ret});

        // reset pulse in the middle of EX
        cyc("rx.if", 3'd0, S_IR);
        cyc("rx.id", 3'd1, S_NONE);
        chk("rx.in_ex", {29'd0, state}, 32'd2);
        rst = 1'b1;
        #1;
        chk("rx.state", {29'd0, state}, 32'd0);
        chk("rx.strb", {27'd0, ir_we, pc_we, rf_we, dm_we, instr_done}, 32'd0);
        chk("rx.retired", {28'd0, retired}, 32'd0);
        chk("rx.halted", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = '0;

        // lw with two dmem wait cycles
        set_instr(6'h23, 6'h00, 1'b1, 1'b0, 2'b10);
        cyc("lw.if", 3'd0, S_IR);
        cyc("lw.id", 3'd1, S_NONE);
        cyc("lw.ex", 3'd2, S_NONE);
        dmem_ready = 1'b0;
        cyc("lw.mem0", 3'd3, S_NONE);
        cyc("lw.mem1", 3'd3, S_NONE);
        dmem_ready = 1'b1;
        cyc("lw.mem2", 3'd3, S_NONE);
        cyc("lw.wb", 3'd4, S_WBK);
        exp_ret = exp_ret + 1'b1;
        chk("lw.retired", {28'd0, retired}, {28'd0, exp_ret});

        // sw, one dmem wait cycle then ready
        set_instr(6'h2B, 6'h00, 1'b0, 1'b1, 2'b00);
        cyc("sw.if", 3'd0, S_IR);
        cyc("sw.id", 3'd1, S_NONE);
        cyc("sw.ex", 3'd2, S_NONE);
        dmem_ready = 1'b0;
        cyc("sw.memw", 3'd3, 5'b00010);
        dmem_ready = 1'b1;
        cyc("sw.mem", 3'd3, S_STDN);
        exp_ret = exp_ret + 1'b1;
        chk("sw.retired", {28'd0, retired}, {28'd0, exp_ret});

        // beq with one imem wait cycle, then j
        set_instr(6'h04, 6'h00, 1'b0, 1'b0, 2'b00);
        imem_ready = 1'b0;
        cyc("beq.ifw", 3'd0, S_NONE);
        imem_ready = 1'b1;
        cyc("beq.if", 3'd0, S_IR);
        cyc("beq.id", 3'd1, S_NONE);
        cyc("beq.ex", 3'd2, S_JMP);
        set_instr(6'h02, 6'h00, 1'b0, 1'b0, 2'b00);
        cyc("j.if", 3'd0, S_IR);
        cyc("j.id", 3'd1, S_NONE);
        cyc("j.ex", 3'd2, S_JMP);
        exp_ret = exp_ret + 4'd2;
        chk("bj.retired", {28'd0, retired}, {28'd0, exp_ret});

        // jal writes the link register through WB
        set_instr(6'h03, 6'h00, 1'b1, 1'b0, 2'b00);
        cyc("jal.if", 3'd0, S_IR);
        cyc("jal.id", 3'd1, S_NONE);
        cyc("jal.ex", 3'd2, S_NONE);
        cyc("jal.wb", 3'd4, S_WBK);
        exp_ret = exp_ret + 1'b1;
        chk("jal.retired", {28'd0, retired}, {28'd0, exp_ret});

        // illegal opcode -> HALT, frozen for 20 cycles
        set_instr(6'h3F, 6'h00, 1'b1, 1'b1, 2'b10);
        cyc("ill.if", 3'd0, S_IR);
        cyc("ill.id", 3'd1, S_NONE);
        for (int i = 0; i < 20; i++) begin
            cyc("ill.halt", 3'd7, S_NONE);
            chk("ill.halted", {31'd0, halted}, 32'd1);
        end
        chk("ill.retired", {28'd0, retired}, {28'd0, exp_ret});
        rst = 1'b1;
        #1;
        chk("ill.clr", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = '0;

        // R-type with an unsupported funct (sub) also halts
        set_instr(6'h00, 6'h22, 1'b1, 1'b0, 2'b00);
        cyc("fn.if", 3'd0, S_IR);
        cyc("fn.id", 3'd1, S_NONE);
        cyc("fn.halt", 3'd7, S_NONE);
        chk("fn.halted", {31'd0, halted}, 32'd1);
        do_reset();

        // 16 retirements wrap the 4-bit counter
        set_instr(6'h04, 6'h00, 1'b0, 1'b0, 2'b00);
        for (int n = 0; n < 16; n++) begin
            cyc("wr.if", 3'd0, S_IR);
            cyc("wr.id", 3'd1, S_NONE);
            cyc("wr.ex", 3'd2, S_JMP);
            exp_ret = exp_ret + 1'b1;
            if (n == 14) chk("wr.r15", {28'd0, retired}, 32'd15);
        end
        chk("wr.wrap", {28'd0, retired}, {28'd0, exp_ret});
        chk("wr.zero", {28'd0, retired}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
